alu16: RTL and testbench
========================

// Module: alu16
// PURPOSE
//  16-bit integer ALU for the FPGA CPU datapath: r1/r2 from the register file, opcode from decode.
//  Registered result written back via rout.
//  Internal status-flag register (C,F,Z,N,L) feeds carry-in for ADDC/SUBC and is exported.
// PARAMETERS
//  WIDTH  16  datapath width (all arithmetic rules below assume 16)
// PORTS
//  clock    in   1   single system clock, rising-edge
//  reset_n  in   1   asynchronous, active-low reset
//  r1       in   16  operand A (destination/first operand)
//  r2       in   16  operand B (source / shift amount)
//  opcode   in   8   operation select
//  rout     out  16  registered result
//  flags    out  5   {C,F,Z,N,L} registered status
// BEHAVIOUR
//  - reset_n=0 (async): rout=16'h0000, flags=5'b0; held while low; mid-operation reset discards pending op.
//  - Latency 1: inputs sampled at rising clock edge; rout/flags valid after that edge. No handshake; new op every cycle.
//  - Opcodes (unlisted -> rout=0, flags unchanged):
//    01 AND r1&r2 | 02 OR r1|r2 | 03 XOR r1^r2 | 04 NOT ~r1
//    05 ADD r1+r2 | 06 ADDU r1+r2 | 07 ADDC r1+r2+C
//    09 SUB r1-r2 | 0A SUBC r1-r2-C | 0B CMP rout=r1-r2
//    0E MUL low 16 bits of r1*r2 (unsigned)
//    84 LSH r1<<r2[3:0] | 0C ALSH r1<<r2[3:0] (zero fill)
//    08 RSH r1>>r2[3:0] logical | 0F ARSH r1>>>r2[3:0] sign fill
//  - Arithmetic: 17-bit internal sum; rout = low 16 bits (wrap-around).
//  - C: ADD/ADDU/ADDC = carry out of bit 15; SUB/SUBC = borrow (unsigned r1 < r2 (+C)).
//  - F: signed overflow; ADD/ADDC: operands same sign, result sign differs.
//    SUB/SUBC: operands differ in sign, result sign != r1 sign. ADDU leaves F unchanged.
//  - CMP: Z=(r1==r2), L=unsigned r1<r2, N=signed r1<r2; C,F unchanged.
//  - Z,N,L updated only by CMP; C updated only by add/sub family; F only by ADD/ADDC/SUB/SUBC.
//  - Logic, shift, MUL, NOT: flags unchanged.
//  - Carry-in for ADDC/SUBC is the registered C from the previous op (back-to-back ok).
//  - Shift amount uses r2[3:0] only; amount 0 passes r1 unchanged.
// TESTING
//  1 ADD r1=3 r2=1 op=05 -> rout=4 after 1 edge, C=0 F=0; reset_n low mid-run -> rout=0 flags=0 immediately.
//  2 ADD 65535+1 -> rout=0 C=1 F=0; ADD 32767+1 -> rout=16'h8000 C=0 F=1; then ADDC 1+1 -> 2 (C=0).
//  3 SUB 2-3 -> 16'hFFFF C=1 F=0; SUB 1-16'hFFFF -> 2 C=1 F=0; SUB 16'h8000-1 -> 16'h7FFF F=1.
//  4 CMP 1,1 -> Z=1 L=0 N=0; CMP 1,2 -> Z=0 L=1 N=1; CMP 16'hFFFF,2 -> L=0 N=1, rout=16'hFFFD.
//  5 Logic/shift r1=1 r2=1: AND=1 OR=1 XOR=0 NOT=16'hFFFE LSH=2 ALSH=2 RSH=0 ARSH=0;
//    ARSH 16'h8000,1 -> 16'hC000; RSH 16'h8000,1 -> 16'h4000.
//  6 MUL 300*300 -> 16'h5F90 (low 16 of 90000); opcode 00/FF -> rout=0, flags held.

Source files
------------

// File: rtl/alu16.sv
// 16-bit single-cycle ALU with registered result and a sticky status-flag register.
// Flag vector is {C,F,Z,N,L}; the registered C feeds the carry-in of ADDC/SUBC.
module alu16 #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [7:0]       opcode,
  output logic [WIDTH-1:0] rout,
  output logic [4:0]       flags
);

  localparam int MSB = WIDTH - 1;
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [7:0] {
    OP_AND  = 8'h01,
    OP_OR   = 8'h02,
    OP_XOR  = 8'h03,
    OP_NOT  = 8'h04,
    OP_ADD  = 8'h05,
    OP_ADDU = 8'h06,
    OP_ADDC = 8'h07,
    OP_RSH  = 8'h08,
    OP_SUB  = 8'h09,
    OP_SUBC = 8'h0A,
    OP_CMP  = 8'h0B,
    OP_ALSH = 8'h0C,
    OP_MUL  = 8'h0E,
    OP_ARSH = 8'h0F,
    OP_LSH  = 8'h84
  } op_e;

  op_e op;
  assign op = op_e'(opcode);

  // Registered state
  logic [WIDTH-1:0] rout_q;
  logic c_q, f_q, z_q, n_q, l_q;

  // Next-state values
  logic [WIDTH-1:0] rout_d;
  logic c_d, f_d, z_d, n_d, l_d;

  // Shared arithmetic: one 17-bit adder and one 17-bit subtractor serve the
  // whole add/sub/compare family; carry-in is only honoured by ADDC/SUBC.
  logic             carry_in;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] mul_lo;
  logic [SHW-1:0]   shamt;

  assign carry_in = c_q & ((op == OP_ADDC) || (op == OP_SUBC));
  assign sum_ext  = {1'b0, r1} + {1'b0, r2} + {{WIDTH{1'b0}}, carry_in};
  assign diff_ext = {1'b0, r1} - {1'b0, r2} - {{WIDTH{1'b0}}, carry_in};

  // Bit WIDTH of diff_ext is the borrow: set whenever r1 < r2 + carry_in.
  assign add_ovf = (r1[MSB] == r2[MSB]) && (sum_ext[MSB]  != r1[MSB]);
  assign sub_ovf = (r1[MSB] != r2[MSB]) && (diff_ext[MSB] != r1[MSB]);

  assign mul_lo = r1 * r2;
  assign shamt  = r2[SHW-1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case can leave a value unassigned and infer a latch.
    rout_d = '0;
    c_d    = c_q;
    f_d    = f_q;
    z_d    = z_q;
    n_d    = n_q;
    l_d    = l_q;

    case (op)
      OP_AND:  rout_d = r1 & r2;
      OP_OR:   rout_d = r1 | r2;
      OP_XOR:  rout_d = r1 ^ r2;
      OP_NOT:  rout_d = ~r1;

      OP_ADD, OP_ADDC: begin
        rout_d = sum_ext[MSB:0];
        c_d    = sum_ext[WIDTH];
        f_d    = add_ovf;
      end
      OP_ADDU: begin
        rout_d = sum_ext[MSB:0];
        c_d    = sum_ext[WIDTH];
      end

      OP_SUB, OP_SUBC: begin
        rout_d = diff_ext[MSB:0];
        c_d    = diff_ext[WIDTH];
        f_d    = sub_ovf;
      end
      OP_CMP: begin
        rout_d = diff_ext[MSB:0];
        z_d    = (r1 == r2);
        l_d    = (r1 < r2);
        n_d    = ($signed(r1) < $signed(r2));
      end

      OP_MUL:          rout_d = mul_lo;
      OP_LSH, OP_ALSH: rout_d = r1 << shamt;
      OP_RSH:          rout_d = r1 >> shamt;
      OP_ARSH:         rout_d = $unsigned($signed(r1) >>> shamt);

      default: rout_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rout_q <= '0;
      c_q    <= 1'b0;
      f_q    <= 1'b0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      l_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      rout_q <= rout_d;
      c_q    <= c_d;
      f_q    <= f_d;
      z_q    <= z_d;
      n_q    <= n_d;
      l_q    <= l_d;
    end
  end

  assign rout  = rout_q;
  assign flags = {c_q, f_q, z_q, n_q, l_q};

endmodule

// File: tb/tb_alu16.sv
// Directed + random bench for alu16: a behavioural model pushes expected
// results into a scoreboard queue, which is popped one cycle later.
module tb_alu16;

  logic        clock;
  logic        reset_n;
  logic [15:0] r1;
  logic [15:0] r2;
  logic [7:0]  opcode;
  logic [15:0] rout;
  logic [4:0]  flags;

  alu16 dut (
    .clock  (clock),
    .reset_n(reset_n),
    .r1     (r1),
    .r2     (r2),
    .opcode (opcode),
    .rout   (rout),
    .flags  (flags)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [15:0] rout;
    logic [4:0]  flags;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  // Model flag state
  logic m_c, m_f, m_z, m_n, m_l;

  localparam logic [7:0] AND_ = 8'h01, OR_ = 8'h02, XOR_ = 8'h03, NOT_ = 8'h04;
  localparam logic [7:0] ADD = 8'h05, ADDU = 8'h06, ADDC = 8'h07, RSH = 8'h08;
  localparam logic [7:0] SUB = 8'h09, SUBC = 8'h0A, CMP = 8'h0B, ALSH = 8'h0C;
  localparam logic [7:0] MUL = 8'h0E, ARSH = 8'h0F, LSH = 8'h84;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Integer-arithmetic reference; updates the model flags as a side effect.
  task automatic model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] res);
    longint ua, ub, sa, sb_, t, cin;
    int     amt;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    amt = int'(b[3:0]);
    res = 16'h0000;
    case (op)
      AND_: res = a & b;
      OR_:  res = a | b;
      XOR_: res = a ^ b;
      NOT_: res = ~a;
      ADD, ADDU, ADDC: begin
        cin = (op == ADDC) ? longint'(m_c) : 0;
        t   = ua + ub + cin;
        res = 16'(t);
        m_c = (t > 65535);
        if (op != ADDU) begin
          t   = sa + sb_ + cin;
          m_f = (t > 32767) || (t < -32768);
        end
      end
      SUB, SUBC: begin
        cin = (op == SUBC) ? longint'(m_c) : 0;
        t   = ua - ub - cin;
        res = 16'(t);
        m_c = (ua < ub + cin);
        t   = sa - sb_ - cin;
        m_f = (t > 32767) || (t < -32768);
      end
      CMP: begin
        res = 16'(ua - ub);
        m_z = (ua == ub);
        m_l = (ua < ub);
        m_n = (sa < sb_);
      end
      MUL:       res = 16'((ua * ub) % 65536);
      LSH, ALSH: res = 16'((ua * (longint'(1) << amt)) % 65536);
      RSH:       res = 16'(ua / (longint'(1) << amt));
      ARSH:      res = 16'(sa >>> amt);
      default:   res = 16'h0000;
    endcase
  endtask

  // Drive one op at the falling edge, predict it, then check it 1 time unit after the rising edge.
  task automatic step(input string tag, input logic [7:0] op, input logic [15:0] a,
                      input logic [15:0] b);
    exp_t        e;
    logic [15:0] res;
    exp_t        got;
    @(negedge clock);
    opcode = op;
    r1     = a;
    r2     = b;
    model(op, a, b, res);
    e.tag   = tag;
    e.rout  = res;
    e.flags = {m_c, m_f, m_z, m_n, m_l};
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 16'h0001, 16'h0000);
    end else begin
      got = sb.pop_front();
      check({got.tag, "_rout"}, rout, got.rout);
      check({got.tag, "_flags"}, {11'd0, flags}, {11'd0, got.flags});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] ops[16];
    ops = '{AND_, OR_, XOR_, NOT_, ADD, ADDU, ADDC, RSH,
            SUB, SUBC, CMP, ALSH, MUL, ARSH, LSH, 8'h0D};
    {m_c, m_f, m_z, m_n, m_l} = 5'b0;
    reset_n = 1'b0;
    r1      = 16'h0;
    r2      = 16'h0;
    opcode  = 8'h00;

    repeat (2) @(posedge clock);
    #1;
    check("reset_rout", rout, 16'h0000);
    check("reset_flags", {11'd0, flags}, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;

    // Basic add, then an asynchronous reset in the middle of the next op
    step("add_3_1", ADD, 16'd3, 16'd1);
    @(negedge clock);
    opcode = ADD; r1 = 16'hFFFF; r2 = 16'h0001;
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_rout", rout, 16'h0000);
    check("midrst_flags", {11'd0, flags}, 16'h0000);
    @(posedge clock);
    #1;
    check("midrst_hold_rout", rout, 16'h0000);
    check("midrst_hold_flags", {11'd0, flags}, 16'h0000);
    opcode = 8'h00;
    {m_c, m_f, m_z, m_n, m_l} = 5'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Carry / overflow boundaries and carry chaining
    step("add_ffff_1", ADD, 16'hFFFF, 16'h0001);
    step("add_7fff_1", ADD, 16'h7FFF, 16'h0001);
    step("addc_1_1", ADDC, 16'h0001, 16'h0001);
    step("add_carry_set", ADD, 16'hFFFF, 16'h0002);
    step("addc_with_c", ADDC, 16'h0001, 16'h0001);
    step("addu_keeps_f", ADDU, 16'h7FFF, 16'h0001);

    // Subtract, borrow, overflow
    step("sub_2_3", SUB, 16'd2, 16'd3);
    step("sub_1_ffff", SUB, 16'h0001, 16'hFFFF);
    step("sub_8000_1", SUB, 16'h8000, 16'h0001);
    step("subc_with_c", SUBC, 16'h0005, 16'h0005);
    step("subc_edge", SUBC, 16'h0000, 16'hFFFF);

    // Compare
    step("cmp_1_1", CMP, 16'd1, 16'd1);
    step("cmp_1_2", CMP, 16'd1, 16'd2);
    step("cmp_ffff_2", CMP, 16'hFFFF, 16'd2);

    // Logic and shifts
    step("and_1_1", AND_, 16'd1, 16'd1);
    step("or_1_1", OR_, 16'd1, 16'd1);
    step("xor_1_1", XOR_, 16'd1, 16'd1);
    step("not_1", NOT_, 16'd1, 16'd1);
    step("lsh_1_1", LSH, 16'd1, 16'd1);
    step("alsh_1_1", ALSH, 16'd1, 16'd1);
    step("rsh_1_1", RSH, 16'd1, 16'd1);
    step("arsh_1_1", ARSH, 16'd1, 16'd1);
    step("arsh_8000_1", ARSH, 16'h8000, 16'd1);
    step("rsh_8000_1", RSH, 16'h8000, 16'd1);
    step("lsh_amt0", LSH, 16'hA5C3, 16'hFFF0);
    step("arsh_amt15", ARSH, 16'h8001, 16'h000F);

    // Multiply and unlisted opcodes
    step("mul_300_300", MUL, 16'd300, 16'd300);
    step("op_00", 8'h00, 16'h1234, 16'h5678);
    step("op_ff", 8'hFF, 16'hFFFF, 16'hFFFF);

    // Random mix
    for (int i = 0; i < 300; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 7 == 0) a = 16'hFFFF;
      if (i % 11 == 0) b = 16'h8000;
      step("rand", ops[$urandom_range(0, 15)], a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
